// File: rtl/prio_arb_pkg.sv
// Shared definitions for the priority / round-robin request arbiter.
//   MODE_FIXED / MODE_RR : values of the arbiter's mode input
//   state_t              : arbiter state (IDLE = no grant, GRANT = grant held)
package prio_arb_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/prio_pick.sv
// Combinational N-bit priority picker with a programmable starting point.
// The search visits start, start-1, ..., 0, N-1, ..., start+1; the first
// set bit wins.
//   vec   : candidate vector
//   start : index with highest priority
//   found : at least one bit of vec is set
//   idx   : index of the winning bit (0 when found is low)
module prio_pick #(
  parameter int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [N-1:0] rot;
  logic [W-1:0] sel;

  // rot[N-1] maps to vec[start], rot[N-2] to vec[start-1], and so on, so a
  // plain descending encode of rot follows the wrapped search order.
  always_comb begin
    rot = '0;
    for (int unsigned j = 0; j < N; j++) begin
      rot[j] = vec[W'((j + 32'(start) + 1) % N)];
    end

    found = 1'b0;
    sel   = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (rot[j]) begin
        found = 1'b1;
        sel   = W'(j);
      end
    end

    idx = found ? W'((32'(sel) + 32'(start) + 1) % N) : '0;
  end

endmodule

// File: rtl/prio_arbiter.sv
// Registered N-way request arbiter.
// Fixed priority (highest index wins) or round-robin (most recent winner
// gets lowest priority), with an optional lock that keeps the current owner
// granted while its request stays high.
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset
//   en      : arbiter enable, low clears the grant
//   mode    : 0 = fixed priority, 1 = round-robin
//   lock    : hold the current grant while its request stays high
//   req     : request vector, bit i = requester i
//   gnt     : one-hot grant, all zero when nothing is granted
//   gnt_idx : index of the granted requester (holds while idle)
//   valid   : gnt is non-zero
module prio_arbiter
  import prio_arb_pkg::*;
#(
  parameter int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         mode,
  input  logic         lock,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         valid
);

  state_t       state, state_n;
  logic [W-1:0] last, last_n;
  logic [N-1:0] gnt_n;
  logic [W-1:0] gnt_idx_n;
  logic         valid_n;

  logic [W-1:0] start;
  logic         found;
  logic [W-1:0] win_idx;

  // Round-robin starts one below the previous winner so that winner ends up
  // last in the search; fixed mode starts at the top with no rotation.
  always_comb begin
    if (mode == MODE_RR) begin
      start = (last == '0) ? W'(N - 1) : last - W'(1);
    end else begin
      start = W'(N - 1);
    end
  end

  prio_pick #(.N(N)) u_pick (
    .vec   (req),
    .start (start),
    .found (found),
    .idx   (win_idx)
  );

  always_comb begin
    state_n   = state;
    last_n    = last;
    gnt_n     = gnt;
    gnt_idx_n = gnt_idx;
    valid_n   = valid;

    if (!en) begin
      state_n = IDLE;
      gnt_n   = '0;
      valid_n = 1'b0;
    end else if (state == GRANT && lock && req[gnt_idx]) begin
      state_n = GRANT;
    end else if (!found) begin
      state_n = IDLE;
      gnt_n   = '0;
      valid_n = 1'b0;
    end else begin
      state_n   = GRANT;
      gnt_n     = N'(1) << win_idx;
      gnt_idx_n = win_idx;
      valid_n   = 1'b1;
      last_n    = win_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last    <= '0;
      gnt     <= '0;
      gnt_idx <= '0;
      valid   <= 1'b0;
    end else begin
      state   <= state_n;
      last    <= last_n;
      gnt     <= gnt_n;
      gnt_idx <= gnt_idx_n;
      valid   <= valid_n;
    end
  end

endmodule

// File: tb/tb_prio_arbiter.sv
// Self-checking bench for prio_arbiter (N = 8): directed sequences with
// literal expectations, then randomized traffic compared every cycle against
// a behavioural model of the arbitration rules.
module tb_prio_arbiter;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst, en, mode, lock;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [2:0]   gnt_idx;
  logic         valid;

  int tests = 0;
  int fails = 0;

  prio_arbiter #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .lock    (lock),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .valid   (valid)
  );

  always #5 clk = ~clk;

  // Behavioural model
  int  m_idx   = 0;
  int  m_last  = 0;
  bit  m_valid = 0;
  bit  started = 0;

  function automatic int pick(logic [N-1:0] r, logic md, int lst);
    if (!md) begin
      for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (lst + N - k) % N;
        if (r[c]) return c;
      end
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    if (rst) begin
      m_idx = 0; m_last = 0; m_valid = 0; started = 1;
    end else if (!en) begin
      m_valid = 0;
    end else if (m_valid && lock && req[m_idx]) begin
      // owner keeps the grant
    end else begin
      w = pick(req, mode, m_last);
      if (w < 0) begin
        m_valid = 0;
      end else begin
        m_valid = 1; m_idx = w; m_last = w;
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("model_valid", int'(valid), int'(m_valid));
      chk("model_gnt", int'(gnt), m_valid ? (1 << m_idx) : 0);
      chk("model_idx", int'(gnt_idx), m_idx);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(string name, int e_gnt, int e_idx, int e_valid);
    chk({name, "_gnt"}, int'(gnt), e_gnt);
    chk({name, "_idx"}, int'(gnt_idx), e_idx);
    chk({name, "_valid"}, int'(valid), e_valid);
  endtask

  initial begin
    rst = 1; en = 1; mode = 0; lock = 0; req = 8'hFF;

    // Reset and idle
    step(); step();
    expect_out("reset", 0, 0, 0);
    rst = 0; req = 8'h00;
    step();
    expect_out("idle", 0, 0, 0);

    // Fixed priority ramp
    for (int i = 0; i < N; i++) begin
      req = 8'((1 << (i + 1)) - 1);
      step();
      expect_out("ramp", 1 << i, i, 1);
    end

    // Round-robin rotation from a fresh reset
    rst = 1; step(); rst = 0;
    mode = 1; req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      step();
      expect_out("rr", 1 << ((7 - i + N) % N), (7 - i + N) % N, 1);
    end

    // Lock hold, then release by dropping the owner's request
    req = 8'h81; lock = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_out("lock_hold", 8'h80, 7, 1);
    end
    req = 8'h01;
    step();
    expect_out("lock_release", 8'h01, 0, 1);

    // Enable drop and reset mid-grant
    lock = 0; mode = 0; req = 8'h25;
    step();
    expect_out("grant5", 8'h20, 5, 1);
    en = 0;
    step();
    expect_out("en_off", 0, 5, 0);
    en = 1;
    step();
    expect_out("en_on", 8'h20, 5, 1);
    rst = 1;
    step();
    expect_out("mid_rst", 0, 0, 0);
    rst = 0; mode = 1; req = 8'hFF;
    step();
    expect_out("post_rst_rr", 8'h80, 7, 1);

    // Mode switch continues round-robin from the last winner
    mode = 0;
    step();
    expect_out("sw_fixed", 8'h80, 7, 1);
    mode = 1;
    step();
    expect_out("sw_rr1", 8'h40, 6, 1);
    step();
    expect_out("sw_rr2", 8'h20, 5, 1);

    // Lock in IDLE has no effect; single requester granted every cycle
    req = 8'h00; lock = 1;
    step();
    expect_out("lock_idle", 0, 5, 0);
    req = 8'h08;
    step();
    expect_out("single1", 8'h08, 3, 1);
    lock = 0;
    step();
    expect_out("single2", 8'h08, 3, 1);

    // Randomized traffic checked by the per-cycle model comparison
    for (int i = 0; i < 600; i++) begin
      rst  = ($urandom_range(0, 99) < 2);
      en   = ($urandom_range(0, 99) < 90);
      mode = 1'($urandom_range(0, 1));
      lock = ($urandom_range(0, 99) < 40);
      case ($urandom_range(0, 3))
        0:       req = 8'(1 << $urandom_range(0, 7));
        1:       req = 8'($urandom) & 8'($urandom);
        2:       req = 8'hFF;
        default: req = 8'($urandom);
      endcase
      step();
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prio_arbiter.md
Name: prio_arbiter

Overview:
- Parametrised, registered successor to the 8x3 priority encoder: N request lines in, one-hot grant plus encoded index out.
- Two modes: fixed priority (highest index wins) and round-robin with rotating priority pointer.
- Optional grant lock holds the current owner across cycles.
- Sits in front of shared resources (bus, memory port) as the request arbiter.

Parameters:
- N, 8, number of requesters (N >= 2).
- W, $clog2(N), width of encoded grant index (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  arbiter enable; 0 clears grant.
- mode  input  1  0 = fixed priority, 1 = round-robin.
- lock  input  1  1 = hold current grant while its request stays high.
- req  input  N  request vector, bit i = requester i.
- gnt  output  N  one-hot grant (all zero when none).
- gnt_idx  output  W  index of granted requester.
- valid  output  1  1 when gnt is non-zero.

Behaviour:
- One clock; reset is synchronous and active-high. All outputs registered.
- Reset (rst=1 at posedge): gnt=0, gnt_idx=0, valid=0, last=0 (internal W-bit pointer), state=IDLE. rst has priority over every other input.
- Latency: req sampled at posedge k, grant visible after posedge k, i.e. one cycle.
- States:
  - IDLE (valid=0).
  - GRANT (valid=1).
- Each posedge, evaluated in priority order:
  1. en=0: gnt=0, valid=0, gnt_idx holds its value, last holds, go to IDLE.
  2. state=GRANT, lock=1, req[gnt_idx]=1: hold gnt, gnt_idx and last unchanged, stay in GRANT.
  3. Otherwise re-arbitrate:
     - req=0: go to IDLE, gnt=0, valid=0, gnt_idx holds.
     - mode=0: winner = highest set index.
     - mode=1: search order last-1, last-2, …, 0, N-1, …, last (wrap modulo N). The first set bit wins. last itself is lowest priority.
     - On a win: gnt=1<<winner, gnt_idx=winner, valid=1, last=winner, go to GRANT.
- last is updated on every win in both modes, so switching to mode=1 continues from the most recent grant. A mode change takes effect at the next arbitration; it never breaks a lock.
- With reset last=0, the first round-robin search order is N-1…0, identical to fixed priority.
- lock while the owner's req drops: normal re-arbitration that same cycle, no idle bubble.
- lock=1 in IDLE: no effect.
- Single requester: granted every cycle in both modes.
- Invariant: gnt is always one-hot or zero, and valid = |gnt.

Decomposition:
- Package prio_arb_pkg: MODE_FIXED=1'b0, MODE_RR=1'b1, state enum (IDLE, GRANT).
- Sub-module prio_pick: combinational N-bit priority picker.
  - Inputs: vector, start index.
  - Outputs: found, index.
  - Internally rotates the vector by start, does a descending priority encode, then un-rotates.
- Fixed mode uses start=N-1 with no rotation; round-robin uses start=last-1 (mod N).

Test Plan:
- Reset/idle: rst=1 for 2 cycles with req=8'hFF → gnt=0, valid=0, gnt_idx=0. Then rst=0, req=0 → remains idle.
- Fixed priority ramp: mode=0, req stepping 01,03,07,…,FF one per cycle → gnt_idx one cycle later = 0,1,2,…,7, gnt=1<<idx.
- Round-robin rotation: mode=1, req=8'hFF held 9 cycles → gnt_idx = 7,6,5,4,3,2,1,0,7.
- Lock hold and release: mode=1, req=8'h81, lock=1 → gnt_idx=7 held 5 cycles. Drop req[7] → next cycle gnt_idx=0, gnt=8'h01.
- Enable and reset mid-grant: during GRANT idx=5, en=0 → next cycle gnt=0, valid=0, gnt_idx=5. en=1 → re-arbitrates. Then rst=1 while valid=1 → next cycle all outputs 0 and last=0, so the next mode=1, req=FF grant is idx 7.
- Mode switch: mode=0, req=FF → idx 7. Switch to mode=1 → next grants 6,5.
